// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the issue control stage: opcodes, control-bit
// positions, the per-lane decode record and the intra-group hazard test.
package ctrl_pkg;

  localparam int         CTRL_W = 13;
  localparam logic [4:0] REG_RA = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam int C_REGDST   = 12;
  localparam int C_ALUSRC   = 11;
  localparam int C_MEMTOREG = 10;
  localparam int C_REGWRITE = 9;
  localparam int C_MEMREAD  = 8;
  localparam int C_MEMWRITE = 7;
  localparam int C_BRANCH   = 6;
  localparam int C_BRANCHNE = 5;
  localparam int C_JUMP     = 4;
  localparam int C_LINK     = 3;
  localparam int C_EXTZERO  = 2;
  localparam int C_ALUOP_HI = 1;
  localparam int C_ALUOP_LO = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} issue_state_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic       illegal;
    logic [4:0] dest;    // 0 when the lane writes no register
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
  } lane_dec_t;

  // True when 'younger' may not share an issue group with 'older'.
  function automatic logic lane_conflict(lane_dec_t older, lane_dec_t younger);
    logic raw, waw, mem, ctl;
    raw = (older.dest != 5'd0) &&
          ((older.dest == younger.rs) || (younger.use_rt && (older.dest == younger.rt)));
    waw = (older.dest != 5'd0) && (older.dest == younger.dest);
    mem = (older.ctrl[C_MEMREAD] | older.ctrl[C_MEMWRITE]) &
          (younger.ctrl[C_MEMREAD] | younger.ctrl[C_MEMWRITE]);
    ctl = older.ctrl[C_BRANCH] | older.ctrl[C_JUMP];
    return raw | waw | mem | ctl;
  endfunction

endpackage

// File: rtl/ctrl_decode_lane.sv
// Combinational single-lane decoder: opcode -> control bundle, legality,
// destination register and source-register usage.
module ctrl_decode_lane
  import ctrl_pkg::*;
#(
  parameter bit EXT_ISA = 1'b1
) (
  input  logic [31:0] instr,
  output lane_dec_t   dec
);

  logic [5:0]  op;
  logic [10:0] unused_low;

  assign op         = instr[31:26];
  assign unused_low = instr[10:0];

  always_comb begin
    dec         = '0;
    dec.rs      = instr[25:21];
    dec.rt      = instr[20:16];
    case (op)
      OP_RTYPE: begin
        dec.ctrl[C_REGDST]   = 1'b1;
        dec.ctrl[C_REGWRITE] = 1'b1;
        dec.ctrl[C_ALUOP_HI] = 1'b1;
        dec.use_rt           = 1'b1;
      end
      OP_LW: begin
        dec.ctrl[C_ALUSRC]   = 1'b1;
        dec.ctrl[C_MEMTOREG] = 1'b1;
        dec.ctrl[C_REGWRITE] = 1'b1;
        dec.ctrl[C_MEMREAD]  = 1'b1;
      end
      OP_SW: begin
        dec.ctrl[C_ALUSRC]   = 1'b1;
        dec.ctrl[C_MEMWRITE] = 1'b1;
        dec.use_rt           = 1'b1;
      end
      OP_BEQ: begin
        dec.ctrl[C_BRANCH]   = 1'b1;
        dec.ctrl[C_ALUOP_LO] = 1'b1;
        dec.use_rt           = 1'b1;
      end
      OP_ADDI: begin
        dec.ctrl[C_ALUSRC]   = 1'b1;
        dec.ctrl[C_REGWRITE] = 1'b1;
      end
      OP_J: dec.ctrl[C_JUMP] = 1'b1;
      OP_ANDI, OP_ORI: begin
        if (EXT_ISA) begin
          dec.ctrl[C_ALUSRC]   = 1'b1;
          dec.ctrl[C_REGWRITE] = 1'b1;
          dec.ctrl[C_EXTZERO]  = 1'b1;
          dec.ctrl[C_ALUOP_HI] = 1'b1;
          dec.ctrl[C_ALUOP_LO] = 1'b1;
        end else dec.illegal = 1'b1;
      end
      OP_SLTI: begin
        if (EXT_ISA) begin
          dec.ctrl[C_ALUSRC]   = 1'b1;
          dec.ctrl[C_REGWRITE] = 1'b1;
          dec.ctrl[C_ALUOP_HI] = 1'b1;
          dec.ctrl[C_ALUOP_LO] = 1'b1;
        end else dec.illegal = 1'b1;
      end
      OP_BNE: begin
        if (EXT_ISA) begin
          dec.ctrl[C_BRANCH]   = 1'b1;
          dec.ctrl[C_BRANCHNE] = 1'b1;
          dec.ctrl[C_ALUOP_LO] = 1'b1;
          dec.use_rt           = 1'b1;
        end else dec.illegal = 1'b1;
      end
      OP_JAL: begin
        if (EXT_ISA) begin
          dec.ctrl[C_JUMP]     = 1'b1;
          dec.ctrl[C_LINK]     = 1'b1;
          dec.ctrl[C_REGWRITE] = 1'b1;
        end else dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Only register-writing lanes carry a destination into hazard checks.
    if (!dec.ctrl[C_REGWRITE])   dec.dest = 5'd0;
    else if (dec.ctrl[C_LINK])   dec.dest = REG_RA;
    else if (dec.ctrl[C_REGDST]) dec.dest = instr[15:11];
    else                         dec.dest = instr[20:16];
  end

endmodule

// File: rtl/issue_ctrl_unit.sv
// Multi-lane decode/issue stage: accepts an instruction bundle, splits it into
// hazard-free in-order groups and registers each group with its control bundles.
module issue_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter bit EXT_ISA     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [32*ISSUE_WIDTH-1:0]     in_instr,
  input  logic [ISSUE_WIDTH-1:0]        in_lanes,
  input  logic                          out_ready,
  output logic [ISSUE_WIDTH-1:0]        out_valid,
  output logic [32*ISSUE_WIDTH-1:0]     out_instr,
  output logic [CTRL_W*ISSUE_WIDTH-1:0] out_ctrl,
  output logic [ISSUE_WIDTH-1:0]        out_illegal
);

  localparam int W = ISSUE_WIDTH;

  issue_state_t                state_q, state_d;
  logic [W-1:0][31:0]          in_lane_instr, hold_instr_q, src_instr;
  logic [W-1:0]                pend_q, pend_d, src_mask, grp;
  logic                        adv, accept;
  lane_dec_t                   dec [W];

  logic [W-1:0][31:0]          oinstr_q, oinstr_d;
  logic [W-1:0][CTRL_W-1:0]    octrl_q, octrl_d;
  logic [W-1:0]                ovalid_d, oill_d;

  assign in_lane_instr = in_instr;
  assign adv           = out_ready | ~(|out_valid);
  assign accept        = in_valid & in_ready;
  assign out_instr     = oinstr_q;
  assign out_ctrl      = octrl_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset || flush) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && (|pend_d))  state_d = ST_HOLD;
      ST_HOLD: if (adv && !(|pend_d))    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs -- HOLD issues from the held bundle, IDLE from the input port
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && adv;
    src_instr = in_lane_instr;
    src_mask  = '0;
    if (state_q == ST_HOLD) begin
      src_instr = hold_instr_q;
      src_mask  = pend_q;
    end else if (in_valid && in_ready) begin
      src_mask  = in_lanes;
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_lane
    ctrl_decode_lane #(.EXT_ISA(EXT_ISA)) u_dec (
      .instr (src_instr[g]),
      .dec   (dec[g])
    );
  end

  // Longest conflict-free run starting at the oldest pending lane.
  always_comb begin
    logic started, stop, hit;
    grp     = '0;
    started = 1'b0;
    stop    = 1'b0;
    hit     = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (src_mask[j] && !stop) begin
        if (!started) begin
          grp[j]  = 1'b1;
          started = 1'b1;
        end else begin
          hit = 1'b0;
          for (int i = 0; i < j; i++)
            if (grp[i] && lane_conflict(dec[i], dec[j])) hit = 1'b1;
          if (hit) stop = 1'b1;
          else     grp[j] = 1'b1;
        end
      end
    end
  end

  assign pend_d = src_mask & ~grp;

  // Pack the group down to output lane 0 upward; unused lanes read as zero.
  always_comb begin
    int cnt;
    ovalid_d = '0;
    oinstr_d = '0;
    octrl_d  = '0;
    oill_d   = '0;
    cnt      = 0;
    for (int j = 0; j < W; j++) begin
      if (grp[j]) begin
        for (int k = 0; k < W; k++) begin
          if (cnt == k) begin
            ovalid_d[k] = 1'b1;
            oinstr_d[k] = src_instr[j];
            octrl_d[k]  = dec[j].ctrl;
            oill_d[k]   = dec[j].illegal;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid    <= '0;
      oinstr_q     <= '0;
      octrl_q      <= '0;
      out_illegal  <= '0;
      pend_q       <= '0;
      hold_instr_q <= '0;
    end else if (adv) begin
      out_valid    <= ovalid_d;
      oinstr_q     <= oinstr_d;
      octrl_q      <= octrl_d;
      out_illegal  <= oill_d;
      pend_q       <= pend_d;
      hold_instr_q <= src_instr;
    end
  end

endmodule

// File: tb/tb_issue_ctrl_unit.sv
// Bench for issue_ctrl_unit (2 lanes): directed vector table, an EXT_ISA=0
// instance for illegal-opcode handling, then random traffic against a queue model.
module tb_issue_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [1:0]  in_lanes;
  logic [63:0] in_instr;

  logic        in_ready, x_in_ready;
  logic [1:0]  out_valid, out_illegal, x_out_valid, x_out_illegal;
  logic [63:0] out_instr, x_out_instr;
  logic [25:0] out_ctrl, x_out_ctrl;

  issue_ctrl_unit #(.ISSUE_WIDTH(2), .EXT_ISA(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lanes(in_lanes), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_ctrl(out_ctrl), .out_illegal(out_illegal));

  issue_ctrl_unit #(.ISSUE_WIDTH(2), .EXT_ISA(1'b0)) dut_base (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(x_in_ready),
    .in_instr(in_instr), .in_lanes(in_lanes), .out_ready(out_ready), .out_valid(x_out_valid),
    .out_instr(x_out_instr), .out_ctrl(x_out_ctrl), .out_illegal(x_out_illegal));

  always #5 clk = ~clk;

  localparam logic [31:0] ADD3 = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADD6 = {6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20};
  localparam logic [31:0] SUB7 = {6'd0, 5'd3, 5'd4, 5'd7, 5'd0, 6'h22};
  localparam logic [31:0] LW2  = {6'h23, 5'd1, 5'd2, 16'd0};
  localparam logic [31:0] SW5  = {6'h2b, 5'd6, 5'd5, 16'd4};
  localparam logic [31:0] BEQ  = {6'h04, 5'd1, 5'd2, 16'd3};
  localparam logic [31:0] LW0  = {6'h23, 5'd1, 5'd0, 16'd0};
  localparam logic [31:0] ADD0 = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20};
  localparam logic [31:0] JAL  = {6'h03, 26'd100};
  localparam logic [31:0] ORI  = {6'h0d, 5'd2, 5'd1, 16'd5};

  int nerr = 0, nchk = 0;

  // Reference model: instructions waiting to issue and the group on the output.
  typedef struct {
    logic [12:0] ctrl;
    bit ill;
    int dest, s1, s2;
    bit mem, ends;
  } mdec_t;

  logic [31:0] mq[$];
  logic [31:0] mo[$];

  // Control bits, MSB first: RegDst ALUSrc MemToReg RegWrite MemRead MemWrite
  // Branch BranchNe Jump Link ExtZero ALUOp[1:0]
  function automatic mdec_t mdec(logic [31:0] ins, bit ext);
    mdec_t d;
    d.ctrl = '0; d.ill = 0; d.dest = 0; d.s1 = ins[25:21]; d.s2 = -1; d.mem = 0; d.ends = 0;
    case (ins[31:26])
      6'h00: begin d.ctrl = 13'b1001000000010; d.dest = ins[15:11]; d.s2 = ins[20:16]; end
      6'h23: begin d.ctrl = 13'b0111100000000; d.dest = ins[20:16]; d.mem = 1; end
      6'h2b: begin d.ctrl = 13'b0100010000000; d.s2 = ins[20:16]; d.mem = 1; end
      6'h04: begin d.ctrl = 13'b0000001000001; d.s2 = ins[20:16]; d.ends = 1; end
      6'h08: begin d.ctrl = 13'b0101000000000; d.dest = ins[20:16]; end
      6'h02: begin d.ctrl = 13'b0000000010000; d.ends = 1; end
      6'h0c, 6'h0d: if (ext) begin d.ctrl = 13'b0101000000111; d.dest = ins[20:16]; end else d.ill = 1;
      6'h0a: if (ext) begin d.ctrl = 13'b0101000000011; d.dest = ins[20:16]; end else d.ill = 1;
      6'h05: if (ext) begin d.ctrl = 13'b0000001100001; d.s2 = ins[20:16]; d.ends = 1; end else d.ill = 1;
      6'h03: if (ext) begin d.ctrl = 13'b0001000011000; d.dest = 31; d.ends = 1; end else d.ill = 1;
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic bit hazard(mdec_t a, mdec_t b);
    if (a.ends) return 1;
    if (a.mem && b.mem) return 1;
    if (a.dest != 0 && (a.dest == b.s1 || a.dest == b.s2 || a.dest == b.dest)) return 1;
    return 0;
  endfunction

  task automatic model_step(bit rst, bit fl, bit iv, logic [1:0] ln, logic [63:0] ins, bit ordy);
    bit adv, rdy, ok;
    adv = ordy || mo.size() == 0;
    rdy = mq.size() == 0 && adv;
    if (rst || fl) begin
      mq.delete(); mo.delete();
    end else if (adv) begin
      if (rdy && iv)
        for (int l = 0; l < 2; l++) if (ln[l]) mq.push_back(ins[32*l +: 32]);
      mo.delete();
      while (mq.size() > 0) begin
        ok = 1;
        foreach (mo[m]) if (hazard(mdec(mo[m], 1), mdec(mq[0], 1))) ok = 0;
        if (mo.size() > 0 && !ok) break;
        mo.push_back(mq.pop_front());
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, check in_ready before the edge, outputs after it.
  task automatic cyc(bit rst, bit fl, bit iv, logic [1:0] ln, logic [31:0] i0, logic [31:0] i1,
                     bit ordy, string tag, output logic rdy_seen);
    logic [1:0]  ev, eil;
    logic [63:0] ei;
    logic [25:0] ec;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_lanes = ln; in_instr = {i1, i0}; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    chk({tag, " in_ready"}, {63'd0, in_ready},
        {63'd0, (mq.size() == 0 && (ordy || mo.size() == 0))});
    model_step(rst, fl, iv, ln, {i1, i0}, ordy);
    @(posedge clk); #1;
    ev = '0; eil = '0; ei = '0; ec = '0;
    foreach (mo[k]) begin
      ev[k] = 1'b1;
      ei[32*k +: 32] = mo[k];
      ec[13*k +: 13] = mdec(mo[k], 1).ctrl;
      eil[k] = mdec(mo[k], 1).ill;
    end
    chk({tag, " out_valid"}, {62'd0, out_valid}, {62'd0, ev});
    chk({tag, " out_instr"}, out_instr, ei);
    chk({tag, " out_ctrl"}, {38'd0, out_ctrl}, {38'd0, ec});
    chk({tag, " out_illegal"}, {62'd0, out_illegal}, {62'd0, eil});
  endtask

  typedef struct {
    bit rst, fl, iv;
    logic [1:0] ln;
    logic [31:0] i0, i1;
    bit ordy;
    logic [1:0] ov;
    bit rdy;
  } vec_t;

  function automatic vec_t mkv(bit rst, bit fl, bit iv, logic [1:0] ln, logic [31:0] i0,
                               logic [31:0] i1, bit ordy, logic [1:0] ov, bit rdy);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ln = ln; v.i0 = i0; v.i1 = i1;
    v.ordy = ordy; v.ov = ov; v.rdy = rdy;
    return v;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] ops [12];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h0c, 6'h0d, 6'h0a, 6'h05, 6'h03, 6'h3f};
    op = ops[$urandom_range(0, 11)];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            11'($urandom)};
  endfunction

  vec_t tv[29];
  logic rs;

  initial begin
    tv[0]  = mkv(1, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[1]  = mkv(0, 0, 1, 2'b11, ADD3, ADD6, 1, 2'b11, 1);  // independent pair
    tv[2]  = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[3]  = mkv(0, 0, 1, 2'b11, ADD3, SUB7, 1, 2'b01, 1);  // RAW split
    tv[4]  = mkv(0, 0, 1, 2'b11, ADD3, ADD6, 1, 2'b01, 0);
    tv[5]  = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[6]  = mkv(0, 0, 1, 2'b11, LW2,  SW5,  1, 2'b01, 1);  // dual memory
    tv[7]  = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b01, 0);
    tv[8]  = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[9]  = mkv(0, 0, 1, 2'b11, BEQ,  ADD3, 1, 2'b01, 1);  // branch ends group
    tv[10] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b01, 0);
    tv[11] = mkv(0, 0, 1, 2'b11, LW0,  ADD0, 1, 2'b11, 1);  // $0 never conflicts
    tv[12] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[13] = mkv(0, 0, 1, 2'b11, ADD3, SUB7, 1, 2'b01, 1);  // stall mid-HOLD
    tv[14] = mkv(0, 0, 0, 2'b00, 0,    0,    0, 2'b01, 0);
    tv[15] = mkv(0, 0, 0, 2'b00, 0,    0,    0, 2'b01, 0);
    tv[16] = mkv(0, 0, 0, 2'b00, 0,    0,    0, 2'b01, 0);
    tv[17] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b01, 0);
    tv[18] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[19] = mkv(0, 0, 1, 2'b11, ADD3, SUB7, 1, 2'b01, 1);  // flush in HOLD
    tv[20] = mkv(0, 1, 1, 2'b11, ADD3, ADD6, 1, 2'b00, 0);
    tv[21] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[22] = mkv(0, 0, 1, 2'b11, ADD3, ADD6, 1, 2'b11, 1);  // IDLE but output blocked
    tv[23] = mkv(0, 0, 1, 2'b11, ADD3, ADD6, 0, 2'b11, 0);
    tv[24] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);
    tv[25] = mkv(0, 0, 1, 2'b11, ADD3, SUB7, 1, 2'b01, 1);  // reset mid-HOLD
    tv[26] = mkv(1, 0, 0, 2'b00, 0,    0,    1, 2'b00, 0);
    tv[27] = mkv(0, 0, 1, 2'b01, JAL,  ADD3, 1, 2'b01, 1);  // single-lane jal
    tv[28] = mkv(0, 0, 0, 2'b00, 0,    0,    1, 2'b00, 1);

    reset = 1; flush = 0; in_valid = 0; in_lanes = 0; in_instr = 0; out_ready = 1;
    repeat (2) @(posedge clk);

    for (int n = 0; n < 29; n++) begin
      string tag;
      tag = $sformatf("v%0d", n);
      cyc(tv[n].rst, tv[n].fl, tv[n].iv, tv[n].ln, tv[n].i0, tv[n].i1, tv[n].ordy, tag, rs);
      chk({tag, " table in_ready"}, {63'd0, rs}, {63'd0, tv[n].rdy});
      chk({tag, " table out_valid"}, {62'd0, out_valid}, {62'd0, tv[n].ov});
      if (n == 27) begin
        chk("jal ctrl", {51'd0, out_ctrl[12:0]}, {51'd0, 13'b0001000011000});
        chk("jal instr", {32'd0, out_instr[31:0]}, {32'd0, JAL});
      end
    end

    // Base-ISA instance: ori is undecodable but still issues alongside the add.
    cyc(1, 0, 0, 2'b00, 0, 0, 1, "base reset", rs);
    cyc(0, 0, 1, 2'b11, ORI, ADD3, 1, "base ori", rs);
    chk("base out_valid", {62'd0, x_out_valid}, {62'd0, 2'b11});
    chk("base out_illegal", {62'd0, x_out_illegal}, {62'd0, 2'b01});
    chk("base out_ctrl", {38'd0, x_out_ctrl}, {38'd0, 13'b1001000000010, 13'b0});

    for (int n = 0; n < 600; n++) begin
      logic [1:0] ln;
      int sel;
      sel = $urandom_range(0, 2);
      ln  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
          ln, rnd_instr(), rnd_instr(), $urandom_range(0, 3) != 0, $sformatf("r%0d", n), rs);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
